// File: rtl/gpio_bank_if.sv
// Shared processor bus bundle as seen by the gpio_bank slave.
// The master modport is the bus-master view, the slave modport is the
// peripheral view. Outputs from slaves are wire-ORed, so an idle slave
// drives all of its outputs to zero.
interface gpio_bank_if;
  logic [31:0] address_data_in;
  logic [3:0]  byte_enables_in;
  logic [7:0]  burst_size_in;
  logic        read_n_write_in;
  logic        begin_transaction_in;
  logic        end_transaction_in;
  logic        data_valid_in;
  logic        busy_in;
  logic [31:0] address_data_out;
  logic        end_transaction_out;
  logic        data_valid_out;
  logic        busy_out;
  logic        error_out;

  modport master (
    output address_data_in, byte_enables_in, burst_size_in, read_n_write_in,
    output begin_transaction_in, end_transaction_in, data_valid_in, busy_in,
    input  address_data_out, end_transaction_out, data_valid_out, busy_out,
    input  error_out
  );

  modport slave (
    input  address_data_in, byte_enables_in, burst_size_in, read_n_write_in,
    input  begin_transaction_in, end_transaction_in, data_valid_in, busy_in,
    output address_data_out, end_transaction_out, data_valid_out, busy_out,
    output error_out
  );
endinterface

// File: rtl/gpio_bank.sv
// gpio_bank: multi-word GPIO slave on the shared processor bus.
// 128-byte window at BASE_ADDRESS:
//   words 0-7   input ports (2-flop synchronised), read-only
//   words 8-15  output registers, read/write with byte lanes
//   word 16/17  IRQ_STATUS / IRQ_MASK (only with GPIO_BANK_IRQ_EN)
//   words 18-31 reserved, read 0
// Optional feature macro: GPIO_BANK_IRQ_EN builds the rising-edge interrupt
// on input word 0. Without it irq is tied low and words 16/17 read 0.
module gpio_bank #(
  parameter logic [31:0] BASE_ADDRESS = 32'h4000_0000,
  parameter int          IN_PORTS     = 1,
  parameter int          OUT_PORTS    = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  gpio_bank_if.slave             bus,
  output logic                   irq,
  input  logic [32*IN_PORTS-1:0] inputs,
  output logic [32*OUT_PORTS-1:0] outputs
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    END_READ = 3'd2,
    WRITE    = 3'd3,
    ERROR    = 3'd4,
    DRAIN    = 3'd5
  } state_t;

  // Registered copies of the bus inputs; all decoding uses these.
  logic [31:0] addr_r;
  logic [3:0]  be_r;
  logic [7:0]  burst_r;
  logic        rnw_r;
  logic        begin_r;
  logic        end_r;
  logic        dv_r;
  logic        busy_r;

  // External input synchroniser.
  logic [32*IN_PORTS-1:0]  sync1_r;
  logic [32*IN_PORTS-1:0]  sync2_r;

  // Output word registers.
  logic [32*OUT_PORTS-1:0] out_regs_r;

  // Transaction context and registered bus outputs.
  state_t      state_r;
  logic [4:0]  word_r;
  logic [3:0]  be_lat_r;
  logic [8:0]  beats_left_r;
  logic        rnw_lat_r;
  logic [31:0] rd_data_r;
  logic        dv_out_r;
  logic        end_out_r;
  logic        err_out_r;

  // Decode helpers.
  logic        in_window_s;
  logic [4:0]  start_word_s;
  logic [8:0]  last_word_s;
  logic        overflow_s;
  logic        write_ro_s;
  logic [31:0] rd_first_s;
  logic [31:0] rd_next_s;
  logic [31:0] wr_mask_s;
  logic        wr_en_s;

`ifdef GPIO_BANK_IRQ_EN
  logic [31:0] irq_status_r;
  logic [31:0] irq_mask_r;
  logic [31:0] irq_prev_r;
  logic        irq_r;
  logic [31:0] rise_s;
  logic [31:0] clear_s;
`endif

  // Expand byte enables into a 32-bit lane mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Value of a word as seen by a read; unimplemented words return 0.
  function automatic logic [31:0] read_value(input logic [4:0] w, input logic [3:0] be);
    logic [31:0] v;
    v = 32'h0000_0000;
    for (int i = 0; i < IN_PORTS; i++) begin
      v = (w == 5'(i)) ? sync2_r[32*i +: 32] : v;
    end
    for (int i = 0; i < OUT_PORTS; i++) begin
      v = (w == 5'(8 + i)) ? out_regs_r[32*i +: 32] : v;
    end
`ifdef GPIO_BANK_IRQ_EN
    v = (w == 5'd16) ? irq_status_r : v;
    v = (w == 5'd17) ? irq_mask_r   : v;
`endif
    return v & lane_mask(be);
  endfunction

  // Register every bus input once before it is used.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_r  <= 32'h0000_0000;
      be_r    <= 4'h0;
      burst_r <= 8'h00;
      rnw_r   <= 1'b0;
      begin_r <= 1'b0;
      end_r   <= 1'b0;
      dv_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      addr_r  <= bus.address_data_in;
      be_r    <= bus.byte_enables_in;
      burst_r <= bus.burst_size_in;
      rnw_r   <= bus.read_n_write_in;
      begin_r <= bus.begin_transaction_in;
      end_r   <= bus.end_transaction_in;
      dv_r    <= bus.data_valid_in;
      busy_r  <= bus.busy_in;
    end
  end

  // Two-flop synchroniser for the asynchronous external inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r <= {(32*IN_PORTS){1'b0}};
      sync2_r <= {(32*IN_PORTS){1'b0}};
    end else begin
      sync1_r <= inputs;
      sync2_r <= sync1_r;
    end
  end

  // Address decode, read-data selection and write strobe.
  always_comb begin
    in_window_s  = (addr_r[31:7] == BASE_ADDRESS[31:7]);
    start_word_s = addr_r[6:2];
    last_word_s  = {4'b0000, start_word_s} + {1'b0, burst_r};
    overflow_s   = (last_word_s > 9'd31);
    write_ro_s   = (start_word_s[4:3] == 2'b00);
    rd_first_s   = read_value(start_word_s, be_r);
    rd_next_s    = read_value(word_r + 5'd1, be_lat_r);
    wr_mask_s    = lane_mask(be_lat_r);
    wr_en_s      = (state_r == WRITE) && dv_r && (beats_left_r != 9'd0);
  end

  // Output word registers, updated under the latched byte lanes.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_regs_r <= {(32*OUT_PORTS){1'b0}};
    end else if (wr_en_s) begin
      for (int i = 0; i < OUT_PORTS; i++) begin
        if (word_r == 5'(8 + i)) begin
          out_regs_r[32*i +: 32] <= (out_regs_r[32*i +: 32] & ~wr_mask_s) |
                                    (addr_r & wr_mask_s);
        end
      end
    end
  end

  // Bus transaction FSM with registered bus outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      word_r       <= 5'd0;
      be_lat_r     <= 4'h0;
      beats_left_r <= 9'd0;
      rnw_lat_r    <= 1'b0;
      rd_data_r    <= 32'h0000_0000;
      dv_out_r     <= 1'b0;
      end_out_r    <= 1'b0;
      err_out_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rd_data_r <= 32'h0000_0000;
          dv_out_r  <= 1'b0;
          end_out_r <= 1'b0;
          err_out_r <= 1'b0;
          if (begin_r && in_window_s) begin
            word_r       <= start_word_s;
            be_lat_r     <= be_r;
            beats_left_r <= {1'b0, burst_r} + 9'd1;
            rnw_lat_r    <= rnw_r;
            if (overflow_s || (!rnw_r && write_ro_s)) begin
              // Read errors close the transaction in the same cycle.
              state_r   <= ERROR;
              err_out_r <= 1'b1;
              end_out_r <= rnw_r;
            end else if (rnw_r) begin
              state_r   <= READ;
              dv_out_r  <= 1'b1;
              rd_data_r <= rd_first_s;
            end else begin
              state_r <= WRITE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          if (busy_r) begin
            // Master stalled: keep presenting the current beat.
            state_r <= READ;
          end else if (beats_left_r == 9'd1) begin
            state_r      <= END_READ;
            beats_left_r <= 9'd0;
            dv_out_r     <= 1'b0;
            rd_data_r    <= 32'h0000_0000;
            end_out_r    <= 1'b1;
          end else begin
            word_r       <= word_r + 5'd1;
            beats_left_r <= beats_left_r - 9'd1;
            rd_data_r    <= rd_next_s;
          end
        end
        END_READ: begin
          end_out_r <= 1'b0;
          state_r   <= IDLE;
        end
        WRITE: begin
          if (wr_en_s) begin
            word_r       <= word_r + 5'd1;
            beats_left_r <= beats_left_r - 9'd1;
          end else begin
            beats_left_r <= beats_left_r;
          end
          state_r <= end_r ? IDLE : WRITE;
        end
        ERROR: begin
          err_out_r <= 1'b0;
          end_out_r <= 1'b0;
          if (rnw_lat_r || end_r) begin
            state_r <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          state_r <= end_r ? IDLE : DRAIN;
        end
        default: begin
          state_r   <= IDLE;
          rd_data_r <= 32'h0000_0000;
          dv_out_r  <= 1'b0;
          end_out_r <= 1'b0;
          err_out_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef GPIO_BANK_IRQ_EN
  // Rising edges of input word 0 and write-one-to-clear strobes.
  always_comb begin
    rise_s = sync2_r[31:0] & ~irq_prev_r;
    if (wr_en_s && (word_r == 5'd16)) begin
      clear_s = addr_r & wr_mask_s;
    end else begin
      clear_s = 32'h0000_0000;
    end
  end

  // Interrupt status, mask and registered irq; an edge beats a clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_prev_r   <= 32'h0000_0000;
      irq_status_r <= 32'h0000_0000;
      irq_mask_r   <= 32'h0000_0000;
      irq_r        <= 1'b0;
    end else begin
      irq_prev_r   <= sync2_r[31:0];
      irq_status_r <= (irq_status_r & ~clear_s) | rise_s;
      if (wr_en_s && (word_r == 5'd17)) begin
        irq_mask_r <= (irq_mask_r & ~wr_mask_s) | (addr_r & wr_mask_s);
      end
      irq_r <= |(irq_status_r & irq_mask_r);
    end
  end

  assign irq = irq_r;
`else
  assign irq = 1'b0;
`endif

  assign outputs                 = out_regs_r;
  assign bus.address_data_out    = rd_data_r;
  assign bus.data_valid_out      = dv_out_r;
  assign bus.end_transaction_out = end_out_r;
  assign bus.error_out           = err_out_r;
  assign bus.busy_out            = 1'b0;

endmodule
